// File: rtl/uart_tx_scheduler_pkg.sv
// Shared peripheral register map and scheduler state encoding for the UART TX scheduler.
package uart_tx_scheduler_pkg;

    localparam logic [31:0] PER_BASE_ADDR     = 32'h4000_0000;
    localparam logic [31:0] PER_GPIO_OUT_ADDR = 32'h4000_0000;
    localparam logic [31:0] PER_GPIO_IN_ADDR  = 32'h4000_0004;
    localparam logic [31:0] PER_TIMER_ADDR    = 32'h4000_0008;
    localparam logic [31:0] PER_TIMER_CMP     = 32'h4000_000C;
    localparam logic [31:0] PER_IRQ_ADDR      = 32'h4000_0010;
    localparam logic [31:0] PER_UART_CON_ADDR = 32'h4000_0014;
    localparam logic [31:0] PER_UART_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] PER_UART_RXD_ADDR = 32'h4000_001C;
    localparam logic [31:0] PER_END_ADDR      = 32'h4000_0020;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

endpackage

// File: rtl/tx_byte_fifo.sv
// Synchronous byte FIFO; a push while full is ignored, a pop while empty is ignored.
module tx_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign head  = mem[rd_ptr];
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Queues bytes and writes them to the UART TXD register in bus cycles the CPU leaves free,
// spacing writes so each one lands after the previous TX_EN stretch has expired.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int          DEPTH    = 16,
    parameter int          GUARD    = 330,
    parameter logic [31:0] TXD_ADDR = PER_UART_TXD_ADDR
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [7:0]             push_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    input  logic                   sched_en,
    input  logic                   tx_busy,
    input  logic                   clr_flags,
    output logic                   ovf,
    output logic                   tx_miss,
    output logic                   active,
    input  logic                   cpu_rd,
    input  logic                   cpu_wr,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wdata,
    output logic                   per_rd,
    output logic                   per_wr,
    output logic [31:0]            per_addr,
    output logic [31:0]            per_wdata
);
    localparam int CW = $clog2(GUARD);

    sched_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_q, seen_d;
    logic          miss_set;
    logic          ovf_set;
    logic          issue;
    logic [7:0]    fifo_head;
    logic          fifo_empty;

    tx_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (issue),
        .head      (fifo_head),
        .full      (full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // Reset also gates issue so the bus is pure CPU pass-through while held.
    assign issue   = ~reset & (state_q == ST_IDLE) & sched_en & ~tx_busy
                   & ~cpu_rd & ~cpu_wr & ~fifo_empty;
    assign active  = (state_q != ST_IDLE);
    assign ovf_set = push & full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            ovf     <= 1'b0;
            tx_miss <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            ovf     <= ovf_set | (ovf & ~clr_flags);
            tx_miss <= miss_set | (tx_miss & ~clr_flags);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        miss_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                end
            end
            ST_ARM: begin
                // The sender must have reported busy at least once while armed.
                if (cnt_q == CW'(GUARD - 1)) begin
                    state_d  = ST_DRAIN;
                    miss_set = ~(seen_q | tx_busy);
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    seen_d = seen_q | tx_busy;
                end
            end
            ST_DRAIN: begin
                if (!tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        per_rd    = cpu_rd;
        per_wr    = cpu_wr;
        per_addr  = cpu_addr;
        per_wdata = cpu_wdata;
        if (issue) begin
            per_rd    = 1'b0;
            per_wr    = 1'b1;
            per_addr  = TXD_ADDR;
            per_wdata = {24'b0, fifo_head};
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios then random traffic against a timestamp-based model.
module tb_uart_tx_scheduler;
    localparam int          DEPTH = 16;
    localparam int          GUARD = 330;
    localparam logic [31:0] TXD   = 32'h4000_0018;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [7:0]  push_data;
    logic        full;
    logic [4:0]  level;
    logic        sched_en;
    logic        tx_busy;
    logic        clr_flags;
    logic        ovf;
    logic        tx_miss;
    logic        active;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        per_rd, per_wr;
    logic [31:0] per_addr, per_wdata;

    uart_tx_scheduler #(.DEPTH(DEPTH), .GUARD(GUARD), .TXD_ADDR(TXD)) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data),
        .full(full), .level(level), .sched_en(sched_en), .tx_busy(tx_busy),
        .clr_flags(clr_flags), .ovf(ovf), .tx_miss(tx_miss), .active(active),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .per_rd(per_rd), .per_wr(per_wr), .per_addr(per_addr), .per_wdata(per_wdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: byte queue plus the timestamp of the write in flight.
    logic [7:0] exp_q[$];
    bit         m_flight = 0;
    int         m_t      = 0;
    bit         m_seen   = 0;
    bit         m_ovf    = 0;
    bit         m_miss   = 0;
    int         obs_wr[$];

    // Emulated sender: busy window placed relative to each scheduler write.
    bit busy_auto = 0;
    bit rnd_busy  = 0;
    int busy_dly  = 10;
    int busy_len  = 50;
    int busy_from = 0;
    int busy_to   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int last_wr();
        return (obs_wr.size() > 0) ? obs_wr[obs_wr.size()-1] : -1;
    endfunction

    function automatic int last_gap();
        return (obs_wr.size() > 1) ? obs_wr[obs_wr.size()-1] - obs_wr[obs_wr.size()-2] : -1;
    endfunction

    task automatic tick();
        bit          e_issue;
        logic        e_wr, e_rd;
        logic [31:0] e_addr, e_wdata;
        bit          was_full, set_ovf, set_miss;
        if (busy_auto) tx_busy = (cyc >= busy_from) && (cyc < busy_to);
        e_issue = !reset && !m_flight && sched_en && !tx_busy && !cpu_rd && !cpu_wr
                  && (exp_q.size() != 0);
        e_wr = cpu_wr; e_rd = cpu_rd; e_addr = cpu_addr; e_wdata = cpu_wdata;
        if (e_issue) begin
            e_wr = 1'b1; e_rd = 1'b0; e_addr = TXD; e_wdata = {24'h0, exp_q[0]};
        end
        #1;
        chk("per_wr", 32'(per_wr), 32'(e_wr));
        chk("per_rd", 32'(per_rd), 32'(e_rd));
        chk("per_addr", per_addr, e_addr);
        chk("per_wdata", per_wdata, e_wdata);
        chk("level", 32'(level), 32'(exp_q.size()));
        chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
        chk("active", 32'(active), 32'(m_flight));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("tx_miss", 32'(tx_miss), 32'(m_miss));
        if (per_wr && !cpu_wr) obs_wr.push_back(cyc);
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            m_flight = 0; m_ovf = 0; m_miss = 0;
        end else begin
            was_full = (exp_q.size() == DEPTH);
            set_ovf = 0; set_miss = 0;
            if (e_issue) begin
                void'(exp_q.pop_front());
                m_flight = 1; m_t = cyc; m_seen = 0;
                if (rnd_busy) begin
                    busy_dly = $urandom_range(1, 200);
                    busy_len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 400);
                end
                busy_from = cyc + busy_dly;
                busy_to   = busy_from + busy_len;
            end else if (m_flight) begin
                // Guard window covers the GUARD cycles after the write; then wait for idle.
                if (cyc <= m_t + GUARD) begin
                    m_seen = m_seen | tx_busy;
                    if (cyc == m_t + GUARD && !m_seen) set_miss = 1;
                end else if (!tx_busy) begin
                    m_flight = 0;
                end
            end
            if (push) begin
                if (was_full) set_ovf = 1;
                else exp_q.push_back(push_data);
            end
            m_ovf  = set_ovf  | (m_ovf  & !clr_flags);
            m_miss = set_miss | (m_miss & !clr_flags);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        push = 1'b1; push_data = b;
        tick();
        push = 1'b0;
    endtask

    task automatic run_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!m_flight && exp_q.size() == 0) break;
            tick();
        end
        #1 chk("idle_reached", 32'(active), 32'(0));
    endtask

    initial begin
        int c0, w;
        reset = 1'b1; push = 1'b0; push_data = '0; sched_en = 1'b1; tx_busy = 1'b0;
        clr_flags = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        @(negedge clk);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Single byte: written the cycle after it is pushed.
        busy_auto = 1; busy_dly = 10; busy_len = 50;
        c0 = cyc;
        push_byte(8'h41);
        tick();
        chk("t1_issue_cycle", 32'(last_wr()), 32'(c0 + 1));
        run_idle(2000);

        // CPU holds the bus for three cycles; scheduler write follows.
        c0 = cyc;
        push_byte(8'h55);
        cpu_wr = 1'b1; cpu_addr = 32'h4000_000C; cpu_wdata = 32'h0000_00AA;
        repeat (3) tick();
        cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        tick();
        chk("t2_issue_cycle", 32'(last_wr()), 32'(c0 + 4));
        run_idle(2000);

        // Back-to-back bytes with a normal busy pulse: GUARD+2 spacing.
        push_byte(8'h10);
        push_byte(8'h20);
        run_idle(3000);
        chk("t3_gap", 32'(last_gap()), 32'(GUARD + 2));
        chk("t3_no_miss", 32'(tx_miss), 32'(0));

        // Long busy: DRAIN holds until busy drops.
        busy_dly = 1; busy_len = 1000;
        push_byte(8'h31);
        push_byte(8'h32);
        run_idle(4000);
        chk("t5_long_gap", 32'(last_gap()), 32'(1002));

        // Busy never rises: tx_miss visible on the first DRAIN cycle.
        busy_len = 0;
        push_byte(8'h33);
        tick();
        w = last_wr();
        for (int i = 0; i < 1000 && cyc < w + GUARD + 1; i++) tick();
        #1 chk("t5_miss_at_drain", 32'(tx_miss), 32'(1));
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        #1 chk("t5_miss_cleared", 32'(tx_miss), 32'(0));
        run_idle(2000);

        // Overflow with scheduling blocked.
        busy_dly = 10; busy_len = 50;
        sched_en = 1'b0;
        for (int i = 0; i < 17; i++) push_byte(8'($urandom_range(0, 255)));
        #1;
        chk("t4_full", 32'(full), 32'(1));
        chk("t4_level", 32'(level), 32'(16));
        chk("t4_ovf", 32'(ovf), 32'(1));
        push = 1'b1; push_data = 8'hEE; clr_flags = 1'b1;
        tick();
        push = 1'b0; clr_flags = 1'b0;
        #1 chk("t4_set_beats_clear", 32'(ovf), 32'(1));
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        #1 chk("t4_ovf_cleared", 32'(ovf), 32'(0));
        sched_en = 1'b1;
        run_idle(8000);

        // Reset mid-ARM with bytes queued and a push in the reset cycle.
        push_byte(8'h61);
        tick();
        for (int i = 0; i < 5; i++) push_byte(8'(8'h70 + i));
        reset = 1'b1; push = 1'b1; push_data = 8'h99;
        tick();
        reset = 1'b0; push = 1'b0;
        #1;
        chk("t6_level", 32'(level), 32'(0));
        chk("t6_active", 32'(active), 32'(0));
        chk("t6_per_wr", 32'(per_wr), 32'(cpu_wr));
        repeat (3) tick();

        // Random traffic.
        rnd_busy = 1;
        for (int i = 0; i < 15000; i++) begin
            push      = ($urandom_range(0, 149) == 0);
            push_data = 8'($urandom_range(0, 255));
            sched_en  = ($urandom_range(0, 49) != 0);
            clr_flags = ($urandom_range(0, 999) == 0);
            cpu_rd    = 1'b0; cpu_wr = 1'b0;
            case ($urandom_range(0, 7))
                0: cpu_rd = 1'b1;
                1: cpu_wr = 1'b1;
                default: ;
            endcase
            cpu_addr  = ($urandom_range(0, 3) == 0) ? TXD : 32'h4000_0000 + 32'($urandom_range(0, 7) * 4);
            cpu_wdata = $urandom;
            tick();
        end
        push = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; clr_flags = 1'b0; sched_en = 1'b1;
        run_idle(20000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
